// File: rtl/sum_pipe_acarreo.sv
// sum_pipe_acarreo: pipelined chunked carry-propagate adder/subtractor.
// Optional signed-overflow output enabled by defining SUMPIPE_OVF_EN.
module sum_pipe_acarreo #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SUMPIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0 || STAGES < 1) begin : g_bad_cfg
    $error("WIDTH must be a multiple of STAGES");
  end

  logic en;

  logic [STAGES-1:0] v_r;
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] co;

  logic [STAGES-1:0][WIDTH-1:0] a_r;
  logic [STAGES-1:0][WIDTH-1:0] b_r;
  logic [STAGES-1:0][WIDTH-1:0] s_r;
  logic [STAGES-1:0][WIDTH-1:0] a_in;
  logic [STAGES-1:0][WIDTH-1:0] b_in;
  logic [STAGES-1:0][WIDTH-1:0] s_in;
  logic [STAGES-1:0][WIDTH-1:0] s_nx;

  logic [CW:0] tmp;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = v_r[STAGES-1];
  assign sum       = s_r[STAGES-1];
  assign cout      = c_r[STAGES-1];

  always_comb begin
    a_in = '0;
    b_in = '0;
    s_in = '0;
    c_in = '0;
    v_in = '0;
    a_in[0] = in_a;
    b_in[0] = sub ? ~in_b : in_b;
    c_in[0] = sub ^ cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_r[k-1];
      b_in[k] = b_r[k-1];
      s_in[k] = s_r[k-1];
      c_in[k] = c_r[k-1];
      v_in[k] = v_r[k-1];
    end
  end

  // Each stage ripples its own chunk; lower finished chunks ride along in s.
  always_comb begin
    tmp  = '0;
    co   = '0;
    s_nx = s_in;
    for (int k = 0; k < STAGES; k++) begin
      tmp = {1'b0, a_in[k][k*CW +: CW]}
          + {1'b0, b_in[k][k*CW +: CW]}
          + {{CW{1'b0}}, c_in[k]};
      co[k] = tmp[CW];
      s_nx[k][k*CW +: CW] = tmp[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r <= '0;
      c_r <= '0;
      s_r <= '0;
      a_r <= '0;
      b_r <= '0;
    end else if (en) begin
      v_r <= v_in;
      c_r <= co;
      s_r <= s_nx;
      a_r <= a_in;
      b_r <= b_in;
    end
  end

  // Operands past the last stage are never consumed.
  logic unused_ops;
  assign unused_ops = ^{a_r[STAGES-1], b_r[STAGES-1]};

`ifdef SUMPIPE_OVF_EN
  logic ovf_r;
  logic a_msb;
  logic b_msb;

  assign a_msb = a_in[STAGES-1][WIDTH-1];
  assign b_msb = b_in[STAGES-1][WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (en) begin
      ovf_r <= (a_msb == b_msb)
            && (s_nx[STAGES-1][WIDTH-1] != a_msb);
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: doc/sum_pipe_acarreo.md
# sum_pipe_acarreo

Parametrised, pipelined carry-propagate adder/subtractor, the streaming successor to the 4-bit combinational ripple-carry adder. The WIDTH-bit operation is split into STAGES equal chunks. Each chunk ripples its carry, and a pipeline register sits between chunks. Operands enter and results leave through valid/ready handshakes, so the block drops directly into the datapath between a producer and a stallable consumer.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset; synchronous and active-low
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (subtract)
- sub  input  1  0 = A+B+cin, 1 = A-B-cin
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out (add); for subtract, 1 = no borrow
- ovf  output  1  signed overflow (only with SUMPIPE_OVF_EN)

## Operation
- Effective operand: b_eff = sub ? ~in_b : in_b.
- Carry into chunk 0: c0 = sub ? ~cin : cin. So subtract is A + ~B + (1 - cin).
- Stage k (0..STAGES-1) adds chunk k of A and b_eff plus the registered carry from stage k-1. In stage 0, it uses c0.
- Upper operand chunks are skewed through delay registers so they reach stage k together with its carry.
- Completed lower sum chunks are deskewed through delay registers so the full sum appears in one cycle.
- A per-stage valid bit travels with the data. out_valid is the valid bit of the last stage.
- Global advance enable: en = !out_valid || out_ready. in_ready = en.
- All stage registers load only when en = 1. Bubbles are not squeezed out.
- The operand transfer occurs when in_valid && in_ready at a rising edge. If in_valid = 0 while en = 1, a bubble (valid = 0) enters stage 0.
- cout is the carry out of the last chunk.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (rst_n low at a rising edge) clears every valid bit, data register and carry register. Outputs after reset: out_valid = 0, sum = 0, cout = 0, ovf = 0, in_ready = 1.
- Latency: a transfer at edge t gives out_valid = 1 with its result after edge t+STAGES-1, with no stalls in between. For STAGES = 1 the result appears the cycle after acceptance.
- Throughput: one result per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, sum/cout/ovf/out_valid hold stable, in_ready = 0, and no stage changes.
- Simultaneous output pop and input push in the same cycle are both honoured; the pipeline shifts by one.
- Reset mid-operation discards every in-flight operation. The first result after reset comes only from operands accepted after reset is released.
- in_ready is combinational from out_ready and out_valid. It has no combinational path from in_valid.

## Configuration
- SUMPIPE_OVF_EN defined:
  - ovf port exists.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), registered alongside the top chunk.
  - ovf follows the same reset, hold and validity rules as sum.
- SUMPIPE_OVF_EN undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Carry ripple across all chunks: A=0xFFFF, B=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, out_valid after edge t+3.
- Subtract with borrow: A=0x0005, B=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0. Then cin=1 -> sum=0xFFFD.
- Streaming: 8 back-to-back operand pairs with out_ready=1 -> 8 consecutive correct results, one per cycle, in order.
- Backpressure: out_ready=0 for 3 cycles while a result is valid -> sum held stable, in_ready=0, no loss or duplication after release.
- Reset mid-stream: rst_n low for 1 cycle with 3 operations in flight -> out_valid=0, sum=0 next cycle. Only post-reset operations emerge.
- Overflow (SUMPIPE_OVF_EN): A=0x7FFF+B=0x0001 -> ovf=1. 0x8000-0x0001 with sub=1 -> ovf=1. 0x0003+0x0004 -> ovf=0.
